rr_priority_arbiter: RTL and testbench
======================================

// Module: rr_priority_arbiter
// PURPOSE
//   Parametrised, registered successor to the 8-to-3 priority encoder.
//   - Selects one of N request lines, in either fixed-priority or round-robin mode.
//   - Presents the winner as a one-hot grant plus a binary index.
//   - Holds the grant with a valid/ready handshake until the consumer accepts it.
//   - Sits between N requesters and a shared resource (bus, port, FIFO write side).
// PARAMETERS
//   N      8   number of requesters; N >= 2
//   IDX_W  3   width of grant_idx; must equal $clog2(N)
//   MODE   1   0 = fixed priority, highest index wins; 1 = round-robin
// PORTS
//   clk          in   1      single clock; all state changes on its rising edge
//   rst          in   1      asynchronous reset, active-high
//   req          in   N      request vector; bit i = requester i
//   grant_ready  in   1      consumer accepts the current grant this cycle
//   grant_valid  out  1      a grant is being presented
//   grant        out  N      one-hot grant; all zero when grant_valid=0
//   grant_idx    out  IDX_W  binary index of the granted requester; 0 when invalid
//   any_req      out  1      combinational OR of req
// BEHAVIOUR
//   Reset
//   - rst=1 forces immediately (asynchronously): grant_valid=0, grant=0, grant_idx=0,
//     ptr=0, state=IDLE.
//   - Reset asserted mid-grant drops the grant with no handshake.
//   - A rising edge with rst still high leaves all state at reset values.
//   Arbitration
//   - Fixed mode (MODE=0): highest set index wins, e.g. req=8'b1100_0000 -> 7.
//   - Round-robin mode (MODE=1): priority order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//     After a grant to k is accepted, ptr <= (k+1) mod N; wrap-around is required.
//   - In fixed mode ptr is held at 0 and never used.
//   State machine
//   - IDLE: if any_req, register the winner -> GRANT. grant_valid rises the cycle
//     after req is seen (latency 1). If req=0, stay in IDLE with outputs unchanged.
//   - GRANT: grant, grant_idx and grant_valid are held stable while grant_ready=0.
//   - GRANT, grant_valid & grant_ready: handshake completes and ptr updates.
//     Re-arbitrate the same cycle using the updated ptr and the current req with the
//     accepted bit masked out.
//     - Another request pending: stay in GRANT with the new winner; back-to-back
//       grants at full rate.
//     - No other request pending: go to IDLE; grant_valid=0 next cycle.
//   - GRANT, withdraw (req[grant_idx]=0 and grant_ready=0): grant is revoked and
//     grant_valid=0 next cycle. ptr is unchanged; -> IDLE.
//   - Ready and withdraw in the same cycle: ready wins, so the grant counts as accepted.
//   - grant_ready is ignored while grant_valid=0.
//   - A new request arriving during GRANT never pre-empts the current grant,
//     even if it has higher priority.
//   Invariants
//   - grant is $onehot0.
//   - grant_valid == |grant.
//   - grant[grant_idx] == grant_valid.
// STRUCTURE
//   Package arb_pkg
//   - state enum {IDLE, GRANT}
//   - MODE_FIXED=0, MODE_RR=1
//   - function onehot_to_idx
//   Sub-module priority_pick (combinational)
//   - Inputs: req[N], ptr[IDX_W], mode.
//   - Outputs: winner one-hot, winner index, found.
//   - RR uses the double-width masked priority trick: {req,req} rotated by ptr.
//   - Reused by the later multi-channel arbiters.
//   Top level
//   - State register, ptr register and output registers only; no combinational path
//     from grant_ready to the outputs.
// TESTING
//   Bench uses N=8, directed checks plus cycle-by-cycle invariant assertions.
//   1. Reset: rst=1 with req=8'hFF, grant_ready=1 -> grant_valid=0, grant=0,
//      grant_idx=0 throughout; first grant is idx 0 one cycle after rst falls (MODE=1).
//   2. Fixed mode: req=8'b1100_0000, grant_ready=0 for 4 cycles -> grant=8'h80,
//      idx=7 held stable; ready=1 -> next grant idx=6.
//   3. RR full load: req=8'hFF, grant_ready=1 continuously -> idx sequence
//      0,1,...,7,0,1, one grant per cycle, no bubbles.
//   4. RR wrap: accept a grant of 6 (ptr=7), then req=8'b0000_0011 -> grant idx 0,
//      then 1; ptr ends at 2.
//   5. Withdraw: grant idx 3 pending, ready=0, drop req[3] -> grant_valid=0 next
//      cycle, ptr unchanged; re-raise req[3] -> idx 3 granted again.
//   6. Idle and reset mid-grant: req=0 for 10 cycles -> grant_valid stays 0;
//      rst pulsed during GRANT -> outputs 0 immediately (async), ptr=0 afterwards.

Source files
------------

// File: rtl/rr_priority_arbiter_pkg.sv
// Shared types and helpers for the request arbiters: FSM states, mode
// encodings and a one-hot to binary index converter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Supports vectors up to 64 bits; callers zero-extend narrower one-hots.
    function automatic int unsigned onehot_to_idx(input logic [63:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (onehot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_arbiter_priority_pick.sv
// Combinational winner selection: fixed priority (highest index wins) or
// round-robin starting at ptr, using the doubled request vector rotated by ptr.
module priority_pick
    import arb_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             found
);

    logic [N-1:0] req_rot;
    int           sel;

    always_comb begin
        req_rot = N'({req, req} >> ptr);
        found   = |req;
        sel     = 0;
        if (mode) begin
            // Lowest set bit of the rotated vector is the first requester at or after ptr.
            for (int i = N - 1; i >= 0; i--) begin
                if (req_rot[i]) begin
                    sel = i;
                end
            end
            sel = sel + int'(ptr);
            if (sel >= N) begin
                sel = sel - N;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    sel = i;
                end
            end
        end
        winner     = found ? (N'(1) << sel) : '0;
        winner_idx = IDX_W'(onehot_to_idx(64'(winner)));
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter presenting a one-hot grant plus index, held under a
// valid/ready handshake; re-arbitrates on acceptance for full-rate grants.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3,
    parameter int MODE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             grant_ready,
    output logic             grant_valid,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    localparam logic MODE_IS_RR = (MODE == MODE_RR);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             grant_valid_q, grant_valid_d;

    logic [IDX_W-1:0] next_ptr;
    logic [N-1:0]     pick_req;
    logic [IDX_W-1:0] pick_ptr;
    logic [N-1:0]     pick_winner;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    assign any_req = |req;

    // On acceptance the picker sees the advanced pointer and the request
    // vector with the accepted requester masked out.
    always_comb begin
        next_ptr = '0;
        if (MODE_IS_RR && (int'(grant_idx_q) < N - 1)) begin
            next_ptr = grant_idx_q + IDX_W'(1);
        end
        ptr_d    = ptr_q;
        pick_req = req;
        pick_ptr = ptr_q;
        if (state_q == GRANT && grant_ready) begin
            ptr_d    = next_ptr;
            pick_req = req & ~grant_q;
            pick_ptr = next_ptr;
        end
    end

    priority_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (pick_req),
        .ptr        (pick_ptr),
        .mode       (MODE_IS_RR),
        .winner     (pick_winner),
        .winner_idx (pick_idx),
        .found      (pick_found)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d       = GRANT;
                    grant_d       = pick_winner;
                    grant_idx_d   = pick_idx;
                    grant_valid_d = 1'b1;
                end
            end
            GRANT: begin
                // Ready takes precedence over a simultaneous withdraw.
                if (grant_ready) begin
                    if (pick_found) begin
                        grant_d       = pick_winner;
                        grant_idx_d   = pick_idx;
                        grant_valid_d = 1'b1;
                    end else begin
                        state_d       = IDLE;
                        grant_d       = '0;
                        grant_idx_d   = '0;
                        grant_valid_d = 1'b0;
                    end
                end else if (!req[grant_idx_q]) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_idx_d   = '0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority instance share
// stimulus and are compared against a queue-free arithmetic reference model.
module tb_rr_priority_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       grantReady;

    logic       rrValid, rrAnyReq;
    logic [7:0] rrGrant;
    logic [2:0] rrIdx;
    logic       fxValid, fxAnyReq;
    logic [7:0] fxGrant;
    logic [2:0] fxIdx;

    int checks = 0;
    int errors = 0;

    // Reference state per instance: index 0 is round-robin, index 1 is fixed.
    bit mValid[2];
    int mIdx[2];
    int mPtr[2];

    rr_priority_arbiter #(.N(8), .IDX_W(3), .MODE(1)) dutRr (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant_ready (grantReady),
        .grant_valid (rrValid),
        .grant       (rrGrant),
        .grant_idx   (rrIdx),
        .any_req     (rrAnyReq)
    );

    rr_priority_arbiter #(.N(8), .IDX_W(3), .MODE(0)) dutFx (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant_ready (grantReady),
        .grant_valid (fxValid),
        .grant       (fxGrant),
        .grant_idx   (fxIdx),
        .any_req     (fxAnyReq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pickWinner(input logic [7:0] r, input int ptr, input bit rr);
        if (rr) begin
            for (int k = 0; k < 8; k++) begin
                if (r[(ptr + k) % 8]) return (ptr + k) % 8;
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            mValid[m] = 1'b0;
            mIdx[m]   = 0;
            mPtr[m]   = 0;
        end
    endtask

    task automatic modelStep(input int m, input logic [7:0] r, input logic rdy);
        int         w;
        logic [7:0] masked;
        if (mValid[m]) begin
            if (rdy) begin
                if (m == 0) mPtr[m] = (mIdx[m] + 1) % 8;
                masked = r;
                masked[mIdx[m]] = 1'b0;
                w = pickWinner(masked, mPtr[m], m == 0);
                if (w >= 0) begin
                    mIdx[m] = w;
                end else begin
                    mValid[m] = 1'b0;
                    mIdx[m]   = 0;
                end
            end else if (!r[mIdx[m]]) begin
                mValid[m] = 1'b0;
                mIdx[m]   = 0;
            end
        end else begin
            w = pickWinner(r, mPtr[m], m == 0);
            if (w >= 0) begin
                mValid[m] = 1'b1;
                mIdx[m]   = w;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkDut(input string tag, input int m, input logic v, input logic [7:0] g,
                            input logic [2:0] idx, input logic anyR);
        logic [7:0] expG;
        expG = mValid[m] ? 8'(1 << mIdx[m]) : 8'h00;
        checkOutput({tag, "_valid"}, v, mValid[m]);
        checkOutput({tag, "_grant"}, g, expG);
        checkOutput({tag, "_idx"}, idx, mValid[m] ? mIdx[m] : 0);
        checkOutput({tag, "_any_req"}, anyR, |req);
        checkOutput({tag, "_onehot0"}, $onehot0(g), 1);
        checkOutput({tag, "_grant_at_idx"}, g[idx], v);
    endtask

    task automatic checkAll();
        checkDut("rr", 0, rrValid, rrGrant, rrIdx, rrAnyReq);
        checkDut("fx", 1, fxValid, fxGrant, fxIdx, fxAnyReq);
    endtask

    // Drive inputs just after an edge, advance the model, then sample 1ns after the next edge.
    task automatic applyStimulus(input logic [7:0] r, input logic rdy);
        req        = r;
        grantReady = rdy;
        if (rst) begin
            modelReset();
        end else begin
            modelStep(0, r, rdy);
            modelStep(1, r, rdy);
        end
        @(posedge clk);
        #1;
        checkAll();
    endtask

    initial begin
        logic [7:0] r;
        logic       rdy;

        rst        = 1'b1;
        req        = 8'hFF;
        grantReady = 1'b1;
        modelReset();
        #1;
        checkAll();
        for (int i = 0; i < 3; i++) applyStimulus(8'hFF, 1'b1);
        rst = 1'b0;

        $display("[TB] round-robin full load");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'hFF, 1'b1);
            checkOutput("rr_seq_idx", rrIdx, i % 8);
            checkOutput("rr_seq_valid", rrValid, 1);
        end

        $display("[TB] fixed priority hold");
        applyStimulus(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'hC0, 1'b0);
            checkOutput("fx_hold_grant", fxGrant, 8'h80);
            checkOutput("fx_hold_idx", fxIdx, 7);
        end
        applyStimulus(8'hC0, 1'b1);
        checkOutput("fx_next_idx", fxIdx, 6);

        $display("[TB] round-robin wrap");
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h40, 1'b0);
        checkOutput("rr_wrap_g6", rrIdx, 6);
        applyStimulus(8'h03, 1'b1);
        checkOutput("rr_wrap_g0", rrIdx, 0);
        applyStimulus(8'h03, 1'b1);
        checkOutput("rr_wrap_g1", rrIdx, 1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("rr_wrap_idle", rrValid, 0);
        applyStimulus(8'hFF, 1'b0);
        checkOutput("rr_wrap_ptr2", rrIdx, 2);

        $display("[TB] withdraw");
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h08, 1'b0);
        checkOutput("rr_wd_g3", rrIdx, 3);
        applyStimulus(8'h00, 1'b0);
        checkOutput("rr_wd_drop", rrValid, 0);
        applyStimulus(8'h08, 1'b0);
        checkOutput("rr_wd_regrant", rrIdx, 3);

        $display("[TB] idle and async reset mid-grant");
        for (int i = 0; i < 10; i++) applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h10, 1'b0);
        checkOutput("rr_pre_rst_valid", rrValid, 1);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkAll();
        applyStimulus(8'h10, 1'b1);
        rst = 1'b0;
        applyStimulus(8'hFF, 1'b0);
        checkOutput("rr_post_rst_idx", rrIdx, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            r = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) r = 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            rdy = 1'($urandom_range(0, 1));
            applyStimulus(r, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
